// File: rtl/seg_scan_arbiter.sv
// Two-requester, frame-aligned owner arbiter that drives a 4-digit multiplexed
// 7-segment display. A requester's data is shadowed only at a frame boundary.
module seg_scan_arbiter #(
    parameter int DIV_MAX = 49999,
    parameter int DIV_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    input  logic        blank_lz,
    output logic        grant0,
    output logic        grant1,
    output logic [6:0]  D,
    output logic [3:0]  An,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    logic [DIV_W-1:0] presc_reg;
    logic [1:0]       idx_reg;
    logic             tick;
    logic             frame_end;

    state_t           state_reg;
    state_t           state_next;
    logic [15:0]      shadow_reg;
    logic             last1_reg;      // 1 when the most recent grant went to requester 1
    logic             win0;
    logic             win1;

    logic             grant0_reg;
    logic             grant1_reg;
    logic             frame_done_reg;
    logic [3:0]       an_reg;
    logic [3:0]       an_next;
    logic [6:0]       d_reg;
    logic [6:0]       d_next;

    logic [3:0]       nib [4];
    logic [3:0]       blank_mask;

    assign tick      = (presc_reg == DIV_W'(DIV_MAX));
    assign frame_end = tick && (idx_reg == 2'd3);

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= 2'd0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + DIV_W'(1);
            if (tick) begin
                idx_reg <= idx_reg + 2'd1;
            end
        end
    end

    // Owner FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Owner FSM: next-state logic, including the round-robin tie break
    always_comb begin
        win0       = 1'b0;
        win1       = 1'b0;
        state_next = state_reg;
        if (frame_end) begin
            if (req0 && req1) begin
                win0 = last1_reg;
                win1 = !last1_reg;
            end else begin
                win0 = req0;
                win1 = req1;
            end
        end
        if (win0) begin
            state_next = OWN0;
        end else if (win1) begin
            state_next = OWN1;
        end
    end

    // Shadow capture, grant bookkeeping and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg     <= 16'h0000;
            last1_reg      <= 1'b1;
            grant0_reg     <= 1'b0;
            grant1_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            grant0_reg     <= win0;
            grant1_reg     <= win1;
            frame_done_reg <= frame_end;
            if (win0) begin
                shadow_reg <= data0;
                last1_reg  <= 1'b0;
            end else if (win1) begin
                shadow_reg <= data1;
                last1_reg  <= 1'b1;
            end
        end
    end

    // Per-digit nibble split and leading-zero blanking mask; digit 0 is never blanked
    assign blank_mask[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = shadow_reg[4*gi +: 4];
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank_mask[gi] = blank_lz & ~(|shadow_reg[15:4*gi]);
        end
    endgenerate

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Owner FSM: output logic (display drive for the current digit slot)
    always_comb begin
        an_next = 4'b1111;
        d_next  = 7'b1111111;
        case (state_reg)
            OWN0, OWN1: begin
                if (!blank_mask[idx_reg]) begin
                    an_next = ~(4'b0001 << idx_reg);
                    d_next  = hex_to_seg(nib[idx_reg]);
                end
            end
            default: begin
                an_next = 4'b1111;
                d_next  = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg <= 4'b1111;
            d_reg  <= 7'b1111111;
        end else begin
            an_reg <= an_next;
            d_reg  <= d_next;
        end
    end

    assign grant0     = grant0_reg;
    assign grant1     = grant1_reg;
    assign frame_done = frame_done_reg;
    assign An         = an_reg;
    assign D          = d_reg;

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 Parameter DIV_MAX, default 49999: clk cycles per digit slot minus one (tick period = DIV_MAX+1).
REQ-002 Parameter DIV_W, default 16: prescaler width, SHALL satisfy 2^DIV_W > DIV_MAX.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  requester 0 (adder result path) wants the display; level-held.
REQ-006 data0  input  16  requester 0 value, 4 hex digits, [3:0]=digit 0 (rightmost).
REQ-007 req1  input  1  requester 1 wants the display; level-held.
REQ-008 data1  input  16  requester 1 value, same format.
REQ-009 blank_lz  input  1  1 = blank leading zero digits.
REQ-010 grant0  output  1  one-cycle pulse: data0 captured.
REQ-011 grant1  output  1  one-cycle pulse: data1 captured.
REQ-012 D  output  7  segments, active-low, D[0]=a ... D[6]=g.
REQ-013 An  output  4  anodes, active-low, An[i] drives digit i.
REQ-014 frame_done  output  1  one-cycle pulse at end of each 4-digit scan.

Function
REQ-015 Prescaler SHALL count 0..DIV_MAX, asserting internal tick when equal to DIV_MAX, then wrap to 0.
REQ-016 Digit index idx (2 bits) SHALL advance on tick, wrapping 3->0; frame end = tick while idx==3.
REQ-017 frame_done SHALL pulse on the cycle after frame end, exactly one cycle.
REQ-018 Owner FSM states: IDLE (no valid shadow), OWN0, OWN1; leaves IDLE or changes owner only at frame end.
REQ-019 At frame end: exactly one req high -> that requester wins; both high -> requester not granted last time wins (round-robin); none high -> state and shadow unchanged.
REQ-020 On winning, shadow register SHALL capture winner's data on the frame-end edge; grantN pulses high the following cycle for one cycle; grant0 and grant1 never high together.
REQ-021 Re-grant to the current owner SHALL still recapture data and pulse its grant (live update once per frame).
REQ-022 Requests arriving mid-frame SHALL wait for the next frame end; requests dropped before frame end are not granted.
REQ-023 In IDLE: An=4'b1111, D=7'b1111111 regardless of idx.
REQ-024 In OWN0/OWN1: An = one-cold of idx; D = hex decode of shadow nibble idx.
REQ-025 Decode (D[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 With blank_lz=1, digit i (i=3..1) SHALL be blanked (An[i]=1, D=1111111) when nibbles 3..i of shadow are all zero; digit 0 never blanked.
REQ-027 An and D SHALL be registered: reflect idx and shadow one clk after idx changes.
REQ-028 blank_lz SHALL be sampled combinationally each cycle into the output register (no frame alignment).

Reset
REQ-029 rst_n low SHALL immediately force: prescaler=0, idx=0, state=IDLE, shadow=16'h0000, last-grant=1 (so req0 wins first tie), An=4'b1111, D=7'b1111111, grant0=grant1=frame_done=0.
REQ-030 Reset asserted mid-frame or mid-grant SHALL abort all activity; after release the first frame end occurs 4*(DIV_MAX+1) cycles later.

Verification (DIV_MAX=3)
REQ-031 Reset released, req0=1, data0=16'h00AB, no req1 -> IDLE blank for 16 cycles, then grant0 pulse, frame_done pulse, then An cycles 1110,1101,1011,0111 every 4 clk showing B,A,0,0.
REQ-032 req0=req1=1 held, data1=16'h1234 -> grants alternate 0,1,0,1 at successive frame ends, never overlapping.
REQ-033 OWN0 with data0=16'h0005, blank_lz=1 -> only digit 0 lit (D=0010010); An[3:1] stay 1 for whole frame; blank_lz=0 -> digits 3..1 show 1000000.
REQ-034 req1 pulsed for 2 cycles mid-frame, low at frame end -> no grant1, owner unchanged.
REQ-035 All 16 nibble values through digit 0 -> D matches REQ-025 table.
REQ-036 rst_n low for 1 cycle during OWN1 with idx=2 -> An=1111, D=1111111 asynchronously; state IDLE; next grant after 16 cycles.
